// File: rtl/div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with tagged results.
module div #(
  parameter int unsigned TAG_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       div_type,
  input  logic [31:0]      in1,
  input  logic [31:0]      in2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [XLEN:0]      rem_q, rem_d;
  logic [XLEN-1:0]    quo_q, quo_d;
  logic [XLEN-1:0]    dsr_q, dsr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic               is_rem_q, is_rem_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [XLEN-1:0]    out_d;
  logic [TAG_W-1:0]   out_tag_d;
  logic               out_valid_d;
  logic               in_ready_d;

  // Operand magnitudes and sign flags for the signed ops
  logic               is_signed;
  logic [XLEN-1:0]    in1_abs, in2_abs;
  logic               overflow;

  assign is_signed = ~div_type[0];
  assign in1_abs   = (is_signed & in1[XLEN-1]) ? -in1 : in1;
  assign in2_abs   = (is_signed & in2[XLEN-1]) ? -in2 : in2;
  assign overflow  = is_signed & (in1 == 32'h8000_0000) & (in2 == 32'hFFFF_FFFF);

  // One restoring step; R[32] is always 0 between steps, so the extra top bit is a clean sign
  logic [XLEN+1:0]    trial;
  logic [XLEN:0]      shifted;
  logic               q_bit;
  logic [XLEN:0]      rem_step;
  logic [XLEN-1:0]    quo_step;
  logic [XLEN-1:0]    result;

  assign trial    = {rem_q, quo_q[XLEN-1]} - {2'b00, dsr_q};
  assign shifted  = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
  assign q_bit    = ~trial[XLEN+1];
  assign rem_step = q_bit ? trial[XLEN:0] : shifted;
  assign quo_step = {quo_q[XLEN-2:0], q_bit};
  assign result   = is_rem_q ? (r_neg_q ? -rem_step[XLEN-1:0] : rem_step[XLEN-1:0])
                             : (q_neg_q ? -quo_step : quo_step);

  // Next-state and next-register logic
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dsr_d       = dsr_q;
    cnt_d       = cnt_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    is_rem_d    = is_rem_q;
    tag_d       = tag_q;
    out_d       = out;
    out_tag_d   = out_tag;
    out_valid_d = out_valid;

    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            dsr_d    = in2_abs;
            q_neg_d  = is_signed & (in1[XLEN-1] ^ in2[XLEN-1]);
            r_neg_d  = is_signed & in1[XLEN-1];
            is_rem_d = div_type[1];
            tag_d    = in_tag;
            rem_d    = '0;
            quo_d    = in1_abs;
            cnt_d    = '1;
            if (in2 == '0) begin
              state_d     = DONE;
              out_valid_d = 1'b1;
              out_tag_d   = in_tag;
              out_d       = div_type[1] ? in1 : 32'hFFFF_FFFF;
            end else if (overflow) begin
              state_d     = DONE;
              out_valid_d = 1'b1;
              out_tag_d   = in_tag;
              out_d       = div_type[1] ? 32'h0000_0000 : 32'h8000_0000;
            end else begin
              state_d = CALC;
            end
          end
        end
        CALC: begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_tag_d   = tag_q;
            out_d       = result;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end
        end
        default: begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      endcase
    end

    in_ready_d = (state_d == IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      cnt_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      is_rem_q  <= 1'b0;
      tag_q     <= '0;
      out       <= '0;
      out_tag   <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dsr_q     <= dsr_d;
      cnt_q     <= cnt_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      is_rem_q  <= is_rem_d;
      tag_q     <= tag_d;
      out       <= out_d;
      out_tag   <= out_tag_d;
      out_valid <= out_valid_d;
      in_ready  <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed spec cases, corner cases and random ops vs. an arithmetic model.
module tb_div;

  localparam int unsigned TAG_W = 6;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       div_type = 2'b00;
  logic [31:0]      in1 = '0;
  logic [31:0]      in2 = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out;
  logic [TAG_W-1:0] out_tag;

  int errors = 0;
  int checks = 0;

  div #(.TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .div_type(div_type),
    .in1(in1), .in2(in2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_tag(out_tag)
  );

  always #5 clock = ~clock;

  // Abort guard so the run always ends
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: RV32M semantics with plain arithmetic
  function automatic logic [31:0] ref_div(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 32'h0) return t[1] ? a : 32'hFFFF_FFFF;
    if (!t[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return t[1] ? 32'h0 : 32'h8000_0000;
    case (t)
      2'b00:   return 32'(sa / sb);
      2'b01:   return a / b;
      2'b10:   return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0) return 1;
    if (!t[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Present one op at a negedge, then count cycles after the accept edge until out_valid (bounded)
  task automatic run_op(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tg, output logic [31:0] res,
                        output logic [TAG_W-1:0] rtag, output int lat);
    @(negedge clock);
    in_valid = 1'b1;
    div_type = t;
    in1      = a;
    in2      = b;
    in_tag   = tg;
    lat      = 0;
    do begin
      @(negedge clock);
      in_valid = 1'b0;
      lat++;
    end while (out_valid !== 1'b1 && lat < 100);
    res  = out;
    rtag = out_tag;
  endtask

  // Accept the held result for one edge
  task automatic ack();
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out !== 32'h0) begin errors++; $display("FAIL reset_out got=%h exp=00000000", out); end
    checks++; if (out_tag !== '0) begin errors++; $display("FAIL reset_out_tag got=%0d exp=0", out_tag); end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [1:0]  tt [12];
    logic [31:0] aa [12];
    logic [31:0] bb [12];
    logic [31:0] ee [12];
    int          ll [12];
    logic [31:0] res;
    logic [TAG_W-1:0] rtag;
    int lat;
    tt = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b01};
    aa = '{32'd100, 32'd100, 32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'd100,
           32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678,
           32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    bb = '{32'd7, 32'd7, 32'd7, 32'd7, 32'hFFFF_FFF9, 32'h0, 32'h0, 32'h0, 32'h0,
           32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    ee = '{32'd14, 32'd2, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678,
           32'h8000_0000, 32'h0, 32'h0};
    ll = '{33, 33, 33, 33, 33, 1, 1, 1, 1, 1, 1, 33};
    for (int i = 0; i < 12; i++) begin
      run_op(tt[i], aa[i], bb[i], TAG_W'(i + 5), res, rtag, lat);
      checks++; if (lat !== ll[i]) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, ll[i]); end
      checks++; if (res !== ee[i]) begin errors++; $display("FAIL dir%0d_out got=%h exp=%h", i, res, ee[i]); end
      checks++; if (rtag !== TAG_W'(i + 5)) begin errors++; $display("FAIL dir%0d_tag got=%0d exp=%0d", i, rtag, i + 5); end
      ack();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL dir%0d_release got valid=%b ready=%b exp valid=0 ready=1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res;
    logic [TAG_W-1:0] rtag;
    int lat;
    int bad;
    run_op(2'b01, 32'd1000, 32'd3, TAG_W'(12), res, rtag, lat);
    checks++; if (res !== 32'd333) begin errors++; $display("FAIL bp_out got=%0d exp=333", res); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (out_valid !== 1'b1 || out !== 32'd333 || out_tag !== TAG_W'(12) || in_ready !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold got=%0d unstable cycles exp=0", bad); end
    ack();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    logic [TAG_W-1:0] rtag;
    int lat;
    int seen;
    run_op(2'b01, 32'd7, 32'd7, TAG_W'(3), res, rtag, lat);
    ack();
    @(negedge clock);
    in_valid = 1'b1; div_type = 2'b01; in1 = 32'd1000; in2 = 32'd3; in_tag = TAG_W'(20);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (14) @(negedge clock);
    flush = 1'b1;
    in_valid = 1'b1; div_type = 2'b01; in1 = 32'd50; in2 = 32'd5; in_tag = TAG_W'(9);
    @(negedge clock);
    flush = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_idle got ready=%b exp=1", in_ready); end
    checks++; if (out !== 32'd1 || out_tag !== TAG_W'(3)) begin
      errors++; $display("FAIL flush_keep got out=%h tag=%0d exp out=00000001 tag=3", out, out_tag);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (out_valid !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_result got=%0d valid cycles exp=0", seen); end
    run_op(2'b01, 32'hFFFF_FFFF, 32'd1, TAG_W'(33), res, rtag, lat);
    checks++; if (res !== 32'hFFFF_FFFF || lat !== 33) begin
      errors++; $display("FAIL after_flush got out=%h lat=%0d exp out=ffffffff lat=33", res, lat);
    end
    ack();
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    logic [TAG_W-1:0] rtag;
    int lat;
    @(negedge clock);
    in_valid = 1'b1; div_type = 2'b01; in1 = 32'd1000; in2 = 32'd3; in_tag = TAG_W'(7);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++; if (out !== 32'h0 || out_valid !== 1'b0 || out_tag !== '0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid got out=%h valid=%b tag=%0d ready=%b exp 0/0/0/1",
                         out, out_valid, out_tag, in_ready);
    end
    run_op(2'b01, 32'd9, 32'd3, TAG_W'(1), res, rtag, lat);
    checks++; if (res !== 32'd3 || rtag !== TAG_W'(1)) begin
      errors++; $display("FAIL after_reset got out=%h tag=%0d exp out=3 tag=1", res, rtag);
    end
    ack();
  endtask

  task automatic test_random();
    logic [1:0]  t;
    logic [31:0] a;
    logic [31:0] b;
    logic [TAG_W-1:0] tg;
    logic [31:0] res;
    logic [TAG_W-1:0] rtag;
    int lat;
    for (int i = 0; i < 40; i++) begin
      t  = 2'($urandom_range(0, 3));
      a  = $urandom;
      tg = TAG_W'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       b = 32'($urandom_range(1, 15));
        2:       begin b = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) a = 32'h8000_0000; end
        3:       begin a = 32'h8000_0000; b = $urandom; end
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_op(t, a, b, tg, res, rtag, lat);
      checks++; if (res !== ref_div(t, a, b)) begin
        errors++; $display("FAIL rnd%0d_out op=%0d a=%h b=%h got=%h exp=%h", i, t, a, b, res, ref_div(t, a, b));
      end
      checks++; if (lat !== ref_lat(t, a, b)) begin
        errors++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, ref_lat(t, a, b));
      end
      checks++; if (rtag !== tg) begin errors++; $display("FAIL rnd%0d_tag got=%0d exp=%0d", i, rtag, tg); end
      ack();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div.md
# div

Iterative radix-2 restoring integer divider for the RV32M DIV, DIVU, REM and REMU operations. It sits in the backend beside the pipelined multiplier, on the long-latency execution port. It takes one operation at a time through a valid/ready handshake and holds its result until the writeback arbiter accepts it. Because the latency varies with the operands, results carry a tag so the ROB/writeback logic can match them to the issuing instruction.

## Interface
- TAG_W, default 6: width of the instruction tag carried from issue to writeback.
- clock  input  1  core clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  pipeline flush; abandons any in-flight operation.
- in_valid  input  1  an operation is presented.
- in_ready  output  1  the divider can accept an operation; high only in IDLE.
- div_type  input  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- in1  input  32  dividend.
- in2  input  32  divisor.
- in_tag  input  TAG_W  tag of the presented operation.
- out_valid  output  1  out and out_tag are valid; held until accepted.
- out_ready  input  1  the consumer accepts the result this cycle.
- out  output  32  quotient or remainder.
- out_tag  output  TAG_W  tag of the result.

## Operation
- Accept: an operation is accepted when in_valid and in_ready are both high at a rising edge. On that edge the divider latches div_type, in_tag, the absolute operands, the quotient sign and the remainder sign.
- Signed ops (DIV, REM):
  - operands are two's-complement; their absolute values are taken.
  - quotient is negative iff in1[31] differs from in2[31].
  - remainder takes the sign of the dividend.
- Unsigned ops (DIVU, REMU): operands are used as-is and no sign correction is applied.
- State machine:
  - IDLE -> CALC on a normal accept.
  - IDLE -> DONE on a special-case accept.
  - CALC -> DONE when the iteration counter reaches 0.
  - DONE -> IDLE when out_ready is high.
  - Any state -> IDLE on flush.
- Special cases are detected at accept and skip CALC:
  - divisor 0: DIV and DIVU give 0xFFFFFFFF; REM and REMU give in1.
  - signed overflow (in1 = 0x80000000, in2 = 0xFFFFFFFF, DIV/REM only): DIV gives 0x80000000; REM gives 0.
- CALC iteration (one per cycle):
  - 33-bit partial remainder R, 32-bit quotient register Q, 5-bit counter starting at 31.
  - Form T = {R[31:0], Q[31]} - {1'b0, divisor}.
  - If T is non-negative: R takes T and the new quotient bit is 1. Otherwise R takes the shifted value and the bit is 0.
  - Q shifts left with the new bit inserted at the LSB. The counter decrements.
- Final iteration (counter = 0): the corrected result is registered into out in the same cycle.
  - Quotient or remainder is selected by div_type[1].
  - Sign correction is a two's-complement negate when required.
- out, out_tag and out_valid are registered outputs and change only on clock edges.
- Reset values: state IDLE, in_ready 1, out_valid 0, out 0x00000000, out_tag 0, internal registers 0.
- flush:
  - Takes priority over every other event, including a simultaneous accept (in_valid ignored) and a simultaneous out_ready.
  - Next cycle: IDLE, out_valid 0. out and out_tag keep their last values.
- reset: takes priority over flush. Mid-operation, it gives the reset values on the next cycle.
- out_valid high with out_ready low: out, out_tag and out_valid hold indefinitely and in_ready stays 0.

## Timing
- Accept at edge E0. Cycles are numbered from E0, cycle k lying between edges E(k-1) and Ek.
- Normal op: CALC occupies cycles 1..32; out_valid rises in cycle 33 (latency 33).
- Special case: out_valid rises in cycle 1 (latency 1).
- DONE with out_ready high at edge Ek: IDLE in cycle k+1, with in_ready 1 and out_valid 0.
- No accept is possible in the same cycle as result delivery. Best-case normal throughput is one op per 34 cycles.
- in_ready is a function of state only, with no combinational path from in_valid, out_ready or flush.

## Test plan
- Reset release, then DIVU 100 / 7 with tag 5: out_valid in cycle 33 after accept, out 14, out_tag 5. Same operands as REMU: out 2.
- DIV 0xFFFFFF9C (-100) / 7: out 0xFFFFFFF2 (-14). REM with the same operands: out 0xFFFFFFFE (-2). REM 100 / 0xFFFFFFF9 (-7): out 2.
- Divide by zero, in1 = 0x12345678: DIV and DIVU give 0xFFFFFFFF; REM and REMU give 0x12345678. out_valid in cycle 1 after accept.
- Overflow 0x80000000 / 0xFFFFFFFF: DIV gives 0x80000000, REM gives 0, each with latency 1. DIVU with the same operands runs the full 33 cycles and gives 0.
- Backpressure: hold out_ready low for 10 cycles after out_valid. Required: out, out_tag and out_valid stable, in_ready 0 throughout. Raise out_ready: IDLE next cycle.
- Flush in CALC cycle 15 with in_valid high: IDLE and out_valid 0 next cycle, no result emitted, the simultaneous op not accepted. Then DIVU 0xFFFFFFFF / 1: out 0xFFFFFFFF. Also assert reset mid-CALC: out 0, out_valid 0 next cycle.
